sms_bk_seq: RTL and testbench

Save-state backup sequencer between hps_io's SD block interface and the system's backup RAM port.
- Tracks whether a writable save image is mounted after a ROM download.
- Turns OSD "Load state" / "Save state" level requests into a 64-sector sd_rd/sd_wr burst at the selected slot's LBA.
- Drives bk_loading, which holds the system in reset during a load.
- Includes an ack watchdog so a stalled HPS transfer cannot hang the core.

---
 rtl/sms_bk_pkg.sv | 14 +
 rtl/sms_bk_watchdog.sv | 30 +++
 rtl/sms_bk_seq.sv | 177 +++++++++++++++++
 tb/tb_sms_bk_seq.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sms_bk_pkg.sv
// Shared state type and default sizing for the SMS save-state backup sequencer.
// Optional autosave support in the top is guarded by SMS_BK_AUTOSAVE_EN.
package sms_bk_pkg;

  typedef enum logic [1:0] {
    BK_IDLE,
    BK_REQ,
    BK_XFER
  } bk_state_t;

  localparam int          BK_LBA_BITS    = 6;
  localparam logic [23:0] BK_TIMEOUT_DEF = 24'd10000000;

endpackage

// File: rtl/sms_bk_watchdog.sv
// Per-sector progress watchdog: counts enabled cycles since the last clear and
// flags expiry once TIMEOUT cycles pass without one.
module sms_bk_watchdog
  import sms_bk_pkg::*;
#(
  parameter logic [23:0] TIMEOUT = BK_TIMEOUT_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [23:0] r_cnt;

  assign o_expired = (r_cnt >= TIMEOUT);

  // Saturates at TIMEOUT so expiry stays asserted until the owner clears it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + 24'd1;
    end
  end

endmodule

// File: rtl/sms_bk_seq.sv
// Save-state backup sequencer: turns OSD load/save requests into 64-sector SD bursts.
// Define SMS_BK_AUTOSAVE_EN to add dirty tracking and an autosave trigger input.
module sms_bk_seq
  import sms_bk_pkg::*;
#(
  parameter int          LBA_BITS = BK_LBA_BITS,
  parameter logic [23:0] TIMEOUT  = BK_TIMEOUT_DEF
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        downloading,
  input  logic        img_mounted,
  input  logic        img_readonly,
  input  logic [63:0] img_size,
  input  logic        bk_load,
  input  logic        bk_save,
  input  logic [1:0]  slot,
  input  logic        sd_ack,
`ifdef SMS_BK_AUTOSAVE_EN
  input  logic        sav_dirty,
  input  logic        autosave_trig,
`endif
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic        bk_ena,
  output logic        bk_loading,
  output logic        bk_busy,
  output logic        bk_error
);

  bk_state_t   r_state, w_state;
  logic [31:0] r_lba, w_lba;
  logic        r_rd, w_rd, r_wr, w_wr;
  logic        r_loading, w_loading, r_busy, w_busy, r_error, w_error;
  logic        r_ena, w_ena;
  logic        r_oldLoad, r_oldSave, r_oldAck, r_oldDl;

  logic w_dlRise, w_ackRise, w_ackFall;
  logic w_loadStart, w_saveStart, w_autoStart;
  logic w_mountSet, w_lastSector, w_wdClr, w_wdExpired;

  assign w_dlRise     = downloading & ~r_oldDl;
  assign w_ackRise    = sd_ack & ~r_oldAck;
  assign w_ackFall    = ~sd_ack & r_oldAck;
  assign w_loadStart  = bk_load & ~r_oldLoad & r_ena;
  assign w_saveStart  = bk_save & ~r_oldSave & r_ena;
  assign w_mountSet   = downloading & img_mounted & (img_size != 64'd0) & ~img_readonly;
  assign w_lastSector = &r_lba[LBA_BITS-1:0];
  assign w_wdClr      = (r_state == BK_IDLE) | w_ackRise | w_ackFall;

  // A fresh mount during a download beats the clear from that download's rising edge.
  assign w_ena = w_mountSet ? 1'b1 : (w_dlRise ? 1'b0 : r_ena);

`ifdef SMS_BK_AUTOSAVE_EN
  logic r_dirty, r_oldTrig, w_saveDone;

  assign w_autoStart = autosave_trig & ~r_oldTrig & r_ena & r_dirty;
  assign w_saveDone  = (r_state == BK_XFER) & w_ackFall & w_lastSector & ~r_loading
                     & ~w_dlRise & ~w_wdExpired;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_dirty   <= 1'b0;
      r_oldTrig <= 1'b0;
    end else begin
      r_dirty   <= sav_dirty | (r_dirty & ~w_saveDone);
      r_oldTrig <= autosave_trig;
    end
  end
`else
  assign w_autoStart = 1'b0;
`endif

  sms_bk_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .i_clk    (clk_sys),
    .i_rst_n  (reset_n),
    .i_clr    (w_wdClr),
    .i_en     (r_state != BK_IDLE),
    .o_expired(w_wdExpired)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= BK_IDLE;
      r_lba     <= '0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_loading <= 1'b0;
      r_busy    <= 1'b0;
      r_error   <= 1'b0;
      r_ena     <= 1'b0;
      r_oldLoad <= 1'b0;
      r_oldSave <= 1'b0;
      r_oldAck  <= 1'b0;
      r_oldDl   <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_lba     <= w_lba;
      r_rd      <= w_rd;
      r_wr      <= w_wr;
      r_loading <= w_loading;
      r_busy    <= w_busy;
      r_error   <= w_error;
      r_ena     <= w_ena;
      r_oldLoad <= bk_load & r_ena;
      r_oldSave <= bk_save & r_ena;
      r_oldAck  <= sd_ack;
      r_oldDl   <= downloading;
    end
  end

  // Burst sequencing; an abort from any active state overrides the per-state result.
  always_comb begin
    w_state   = r_state;
    w_lba     = r_lba;
    w_rd      = r_rd;
    w_wr      = r_wr;
    w_loading = r_loading;
    w_busy    = r_busy;
    w_error   = r_error;
    case (r_state)
      BK_IDLE: begin
        if (w_loadStart || w_saveStart || w_autoStart) begin
          w_state   = BK_REQ;
          w_lba     = {{(30-LBA_BITS){1'b0}}, slot, {LBA_BITS{1'b0}}};
          w_rd      = w_loadStart;
          w_wr      = ~w_loadStart;
          w_loading = w_loadStart;
          w_busy    = 1'b1;
          w_error   = 1'b0;
        end
      end
      BK_REQ: begin
        if (w_ackRise) begin
          w_rd    = 1'b0;
          w_wr    = 1'b0;
          w_state = BK_XFER;
        end
      end
      BK_XFER: begin
        if (w_ackFall) begin
          if (w_lastSector) begin
            w_state   = BK_IDLE;
            w_busy    = 1'b0;
            w_loading = 1'b0;
          end else begin
            w_lba[LBA_BITS-1:0] = r_lba[LBA_BITS-1:0] + LBA_BITS'(1);
            w_rd    = r_loading;
            w_wr    = ~r_loading;
            w_state = BK_REQ;
          end
        end
      end
      default: w_state = BK_IDLE;
    endcase
    if ((r_state != BK_IDLE) && (w_dlRise || w_wdExpired)) begin
      w_state   = BK_IDLE;
      w_rd      = 1'b0;
      w_wr      = 1'b0;
      w_busy    = 1'b0;
      w_loading = 1'b0;
      w_error   = ~w_dlRise;
    end
  end

  assign sd_lba     = r_lba;
  assign sd_rd      = r_rd;
  assign sd_wr      = r_wr;
  assign bk_ena     = r_ena;
  assign bk_loading = r_loading;
  assign bk_busy    = r_busy;
  assign bk_error   = r_error;

endmodule

// File: tb/tb_sms_bk_seq.sv
// Directed bench for sms_bk_seq with a small HPS ack model; the watchdog is shortened to 100 cycles.
// Autosave steps are included when SMS_BK_AUTOSAVE_EN is defined.
module tb_sms_bk_seq;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        downloading, img_mounted, img_readonly;
  logic [63:0] img_size;
  logic        bk_load, bk_save;
  logic [1:0]  slot;
  logic        sd_ack;
`ifdef SMS_BK_AUTOSAVE_EN
  logic        sav_dirty, autosave_trig;
`endif
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, bk_ena, bk_loading, bk_busy, bk_error;

  int total = 0;
  int bad   = 0;

  int          reqCount, rdCount, wrCount, lbaErrors, busyErrors, stallIndex, stallCycles, idx;
  logic [31:0] expLba;
  logic        busyAtDrop, busyAfterDrop, loadingAfterDrop;
  bit          skipWait;

  sms_bk_seq #(
    .LBA_BITS(6),
    .TIMEOUT (24'd100)
  ) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .downloading  (downloading),
    .img_mounted  (img_mounted),
    .img_readonly (img_readonly),
    .img_size     (img_size),
    .bk_load      (bk_load),
    .bk_save      (bk_save),
    .slot         (slot),
    .sd_ack       (sd_ack),
`ifdef SMS_BK_AUTOSAVE_EN
    .sav_dirty    (sav_dirty),
    .autosave_trig(autosave_trig),
`endif
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .bk_ena       (bk_ena),
    .bk_loading   (bk_loading),
    .bk_busy      (bk_busy),
    .bk_error     (bk_error)
  );

  always #5 clk_sys = ~clk_sys;

  // HPS model: acks each sector request 5 cycles after seeing it, except the stall index.
  always begin
    if (!skipWait) @(negedge clk_sys);
    skipWait = 1'b0;
    if ((sd_rd || sd_wr) && !sd_ack) begin
      idx = reqCount;
      reqCount++;
      if (sd_rd) rdCount++;
      if (sd_wr) wrCount++;
      if (sd_lba !== expLba) lbaErrors++;
      if (bk_busy !== 1'b1) busyErrors++;
      expLba++;
      if (idx == stallIndex) begin
        stallCycles = 0;
        while ((sd_rd || sd_wr) && stallCycles < 5000) begin
          @(negedge clk_sys);
          stallCycles++;
        end
      end else begin
        repeat (5) @(negedge clk_sys);
        sd_ack = 1'b1;
        repeat (2) @(negedge clk_sys);
        busyAtDrop = bk_busy;
        sd_ack     = 1'b0;
        @(negedge clk_sys);
        busyAfterDrop    = bk_busy;
        loadingAfterDrop = bk_loading;
        skipWait         = 1'b1;
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not reach its end");
    $fatal(1, "[TB] global timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic load, input logic save);
    bk_load = load;
    bk_save = save;
    tick(1);
  endtask

  task automatic mountPulse(input logic ro, input logic [63:0] size);
    img_readonly = ro;
    img_size     = size;
    img_mounted  = 1'b1;
    tick(1);
    img_mounted  = 1'b0;
    tick(1);
  endtask

  task automatic resetModel(input logic [31:0] firstLba);
    reqCount   = 0;
    rdCount    = 0;
    wrCount    = 0;
    lbaErrors  = 0;
    busyErrors = 0;
    stallIndex = -1;
    expLba     = firstLba;
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n = 0;
    while (bk_busy === 1'b1 && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    checkOutput(tag, 32'(n < budget), 32'd1);
  endtask

  initial begin
    int n;
    reset_n = 1'b0; downloading = 1'b0; img_mounted = 1'b0; img_readonly = 1'b0;
    img_size = 64'd0; bk_load = 1'b0; bk_save = 1'b0; slot = 2'd0; sd_ack = 1'b0;
`ifdef SMS_BK_AUTOSAVE_EN
    sav_dirty = 1'b0; autosave_trig = 1'b0;
`endif
    skipWait = 1'b0; stallCycles = 0;
    busyAtDrop = 1'b0; busyAfterDrop = 1'b0; loadingAfterDrop = 1'b0;
    resetModel(32'd0);
    tick(3);
    checkOutput("rst_lba", sd_lba, 32'd0);
    checkOutput("rst_rd", sd_rd, 32'd0);
    checkOutput("rst_wr", sd_wr, 32'd0);
    checkOutput("rst_ena", bk_ena, 32'd0);
    checkOutput("rst_busy", bk_busy, 32'd0);
    checkOutput("rst_loading", bk_loading, 32'd0);
    checkOutput("rst_error", bk_error, 32'd0);
    reset_n = 1'b1;
    tick(2);

    // Mount handling
    downloading = 1'b1;
    tick(2);
    mountPulse(1'b0, 64'd32768);
    checkOutput("mount_ena", bk_ena, 32'd1);
    downloading = 1'b0;
    tick(2);
    checkOutput("ena_hold", bk_ena, 32'd1);
    downloading = 1'b1;
    tick(1);
    checkOutput("dl_rise_clear", bk_ena, 32'd0);
    mountPulse(1'b1, 64'd32768);
    checkOutput("ro_mount", bk_ena, 32'd0);
    mountPulse(1'b0, 64'd0);
    checkOutput("zero_size_mount", bk_ena, 32'd0);
    mountPulse(1'b0, 64'd32768);
    checkOutput("remount_ena", bk_ena, 32'd1);
    downloading = 1'b0;
    tick(2);

    // Save to slot 2
    resetModel(32'd128);
    slot = 2'd2;
    applyStimulus(1'b0, 1'b1);
    checkOutput("save2_busy", bk_busy, 32'd1);
    checkOutput("save2_wr", sd_wr, 32'd1);
    checkOutput("save2_lba0", sd_lba, 32'd128);
    checkOutput("save2_loading", bk_loading, 32'd0);
    bk_save = 1'b0;
    waitIdle("save2_done", 3000);
    tick(3);
    checkOutput("save2_wr_count", wrCount, 32'd64);
    checkOutput("save2_rd_count", rdCount, 32'd0);
    checkOutput("save2_lba_order", lbaErrors, 32'd0);
    checkOutput("save2_busy_each", busyErrors, 32'd0);
    checkOutput("save2_busy_at_drop", busyAtDrop, 32'd1);
    checkOutput("save2_busy_after_drop", busyAfterDrop, 32'd0);
    checkOutput("save2_last_lba", sd_lba, 32'd191);

    // Load from slot 3, slot changes mid-burst
    resetModel(32'd192);
    slot = 2'd3;
    applyStimulus(1'b1, 1'b0);
    checkOutput("load3_loading", bk_loading, 32'd1);
    checkOutput("load3_rd", sd_rd, 32'd1);
    checkOutput("load3_lba0", sd_lba, 32'd192);
    bk_load = 1'b0;
    tick(20);
    slot = 2'd0;
    waitIdle("load3_done", 3000);
    tick(3);
    checkOutput("load3_rd_count", rdCount, 32'd64);
    checkOutput("load3_wr_count", wrCount, 32'd0);
    checkOutput("load3_lba_order", lbaErrors, 32'd0);
    checkOutput("load3_loading_after", loadingAfterDrop, 32'd0);
    checkOutput("load3_last_lba", sd_lba, 32'd255);

    // Load and save rising together, then a save edge while busy
    resetModel(32'd64);
    slot = 2'd1;
    applyStimulus(1'b1, 1'b1);
    checkOutput("both_loading", bk_loading, 32'd1);
    checkOutput("both_rd", sd_rd, 32'd1);
    bk_save = 1'b0;
    tick(30);
    bk_save = 1'b1;
    tick(1);
    bk_save = 1'b0;
    waitIdle("both_done", 3000);
    tick(5);
    checkOutput("both_rd_count", rdCount, 32'd64);
    checkOutput("both_wr_count", wrCount, 32'd0);
    checkOutput("both_lba_order", lbaErrors, 32'd0);
    checkOutput("both_no_queue", bk_busy, 32'd0);
    bk_load = 1'b0;
    tick(2);

    // Watchdog: sector 5 of a load is never acknowledged
    resetModel(32'd0);
    stallIndex = 5;
    slot = 2'd0;
    applyStimulus(1'b1, 1'b0);
    bk_load = 1'b0;
    waitIdle("wd_done", 3000);
    checkOutput("wd_rd", sd_rd, 32'd0);
    checkOutput("wd_error", bk_error, 32'd1);
    checkOutput("wd_busy", bk_busy, 32'd0);
    checkOutput("wd_loading", bk_loading, 32'd0);
    tick(3);
    checkOutput("wd_cycles", stallCycles, 32'd101);
    checkOutput("wd_req_count", reqCount, 32'd6);

    resetModel(32'd128);
    slot = 2'd2;
    applyStimulus(1'b0, 1'b1);
    checkOutput("wd_error_cleared", bk_error, 32'd0);
    bk_save = 1'b0;
    waitIdle("post_wd_done", 3000);
    tick(3);
    checkOutput("post_wd_wr_count", wrCount, 32'd64);

    // Download rising mid-save aborts without error and disables backups
    resetModel(32'd192);
    slot = 2'd3;
    applyStimulus(1'b0, 1'b1);
    bk_save = 1'b0;
    n = 0;
    while (reqCount < 11 && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    checkOutput("abort_reach_sector10", 32'(n < 2000), 32'd1);
    downloading = 1'b1;
    tick(1);
    checkOutput("abort_wr", sd_wr, 32'd0);
    checkOutput("abort_busy", bk_busy, 32'd0);
    checkOutput("abort_error", bk_error, 32'd0);
    checkOutput("abort_ena", bk_ena, 32'd0);
    tick(20);
    applyStimulus(1'b0, 1'b1);
    tick(2);
    checkOutput("abort_save_ignored", bk_busy, 32'd0);
    checkOutput("abort_save_no_wr", sd_wr, 32'd0);
    bk_save = 1'b0;

`ifdef SMS_BK_AUTOSAVE_EN
    // Autosave after a dirty pulse, then a trigger with nothing dirty
    mountPulse(1'b0, 64'd32768);
    downloading = 1'b0;
    tick(2);
    sav_dirty = 1'b1;
    tick(1);
    sav_dirty = 1'b0;
    resetModel(32'd64);
    slot = 2'd1;
    autosave_trig = 1'b1;
    tick(1);
    checkOutput("auto_busy", bk_busy, 32'd1);
    checkOutput("auto_wr", sd_wr, 32'd1);
    waitIdle("auto_done", 3000);
    tick(3);
    checkOutput("auto_wr_count", wrCount, 32'd64);
    checkOutput("auto_lba_order", lbaErrors, 32'd0);
    autosave_trig = 1'b0;
    tick(2);
    autosave_trig = 1'b1;
    tick(2);
    checkOutput("auto_clean_no_burst", bk_busy, 32'd0);
    autosave_trig = 1'b0;
`endif

    downloading = 1'b0;
    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
